fp64_align_unpack: RTL
======================

Name: fp64_align_unpack

Overview:
- Front end of the pipelined double-precision adder; the counterpart of the normalise/pack stage.
- Unpacks two IEEE-754 binary64 operands and orders them by magnitude.
- Right-aligns the smaller mantissa to the larger exponent.
- Emits the unbiased exponent, the aligned 54-bit mantissas, the result sign and the effective-subtract flag for the add/sub stage.
- 2-stage pipeline with valid/ready handshake on both sides.

Parameters:
- MANT_W, 52, stored fraction width.
- EXP_W, 11, exponent width.
- BIAS, 1023, exponent bias removed on output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  64  operand A, {sign, exp[10:0], frac[51:0]}.
- b  input  64  operand B, same format.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts result.
- bigshift  output  11  unbiased exponent of the larger operand (biased − BIAS), two's complement.
- smallshift  output  11  exponent difference (big − small), unsigned.
- bigmant  output  54  {0, hidden bit, frac} of the larger operand.
- smallmant  output  54  smaller operand's {0, hidden, frac} shifted right by smallshift.
- resultsign  output  1  sign of the larger-magnitude operand.
- effsub  output  1  a.sign XOR b.sign.
- special  output  1  either operand has exp = 2047 (Inf/NaN).

Behaviour:
- Reset: all output registers, both stage valid bits, out_valid, in_ready-gating state go to 0. rst takes priority over every other event and discards in-flight data.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load; it is combinational and does not depend on in_valid.
  - Outputs hold stable while out_valid && !out_ready.
- Latency: 2 cycles from accepted input to out_valid with no backpressure. Throughput 1 per cycle.
- Stage 1 (unpack/compare):
  - Hidden bit = (exp != 0). exp = 0 is treated as zero, so denormals flush to zero: mantissa forced to 0, exponent taken as 0.
  - Magnitude compare uses {exp, frac}. Swap when |b| > |a|. On equality, A is "big".
  - diff = exp_big − exp_small, 11-bit unsigned.
  - Registers big/small mantissas (53b), exp_big, diff, resultsign, effsub and special.
- Stage 2 (align):
  - smallmant = {0, small53} >> diff. If diff ≥ 54, smallmant = 0. Truncated bits are discarded; there are no guard or sticky bits.
  - bigmant = {0, big53}.
  - bigshift = exp_big − 1023, in 11-bit wraparound arithmetic.
  - smallshift = diff.
- Both operands zero: all mantissas 0, bigshift = −1023 (0x401), resultsign = a.sign.
- special: the flag is asserted and the remaining fields are computed by the normal rules. Downstream owns Inf/NaN handling.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.

Test Plan:
- Basic add: a = 0x3FF0000000000000 (1.0), b = 0x3FE0000000000000 (0.5), out_ready = 1. Required after 2 cycles:
  - bigshift = 0, smallshift = 1.
  - bigmant = 0x10000000000000, smallmant = 0x08000000000000.
  - effsub = 0, resultsign = 0.
- Swap and subtract: a = 0x3FE0000000000000, b = 0xC000000000000000 (−2.0). Required:
  - bigshift = 1, smallshift = 2.
  - bigmant = 0x10000000000000, smallmant = 0x04000000000000.
  - resultsign = 1, effsub = 1.
- Large shift: a = 0x4340000000000000 (2^53), b = 0x3FF0000000000000. Required: smallshift = 53, smallmant = 0x0000000000000000.
- Zero/special: a = 0, b = 0 → bigshift = 0x401, both mantissas 0. a = 0x7FF0000000000000 → special = 1.
- Backpressure: stream 4 pairs with out_ready held low for 3 cycles after the first result. Required:
  - in_ready drops once both stages are full.
  - Outputs are held stable while stalled.
  - All 4 results emerge in order with none lost or duplicated.
- Reset mid-stream: assert rst with both stages full. Required: next cycle out_valid = 0, in_ready = 1, and no stale result appears after rst deasserts.

Source files
------------

// File: rtl/fp64_align_unpack_if.sv
// Operand/result bundle for the fp64 adder front end (unpack + align).
// Ports: in_valid/in_ready/a/b toward the producer; out_valid/out_ready plus
// bigshift, smallshift, bigmant, smallmant, resultsign, effsub, special toward the add stage.
interface fp64_align_unpack_if #(
   parameter int MANT_W = 52,
   parameter int EXP_W  = 11
);
   localparam int W = 1 + EXP_W + MANT_W;

   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      a;
   logic [W-1:0]      b;
   logic              out_valid;
   logic              out_ready;
   logic [EXP_W-1:0]  bigshift;
   logic [EXP_W-1:0]  smallshift;
   logic [MANT_W+1:0] bigmant;
   logic [MANT_W+1:0] smallmant;
   logic              resultsign;
   logic              effsub;
   logic              special;

   // Producer / consumer side (testbench or surrounding datapath).
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, bigshift, smallshift, bigmant, smallmant,
             resultsign, effsub, special
   );

   // Block side.
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, bigshift, smallshift, bigmant, smallmant,
             resultsign, effsub, special
   );
endinterface

// File: rtl/fp64_align_unpack.sv
// Purpose: unpack two binary64 operands, order by magnitude, right-align the smaller mantissa.
// Latency: 2 cycles (stage 1 unpack/compare, stage 2 align), throughput 1 per cycle.
// Backpressure: valid/ready; in_ready = !s1_valid || !s2_valid || out_ready, outputs hold while stalled.
// Ports: clk, rst (sync, active-high), io (slave): in_valid/in_ready/a/b in,
//        out_valid/out_ready, bigshift, smallshift, bigmant, smallmant, resultsign, effsub, special out.
module fp64_align_unpack #(
   parameter int MANT_W = 52,
   parameter int EXP_W  = 11,
   parameter int BIAS   = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   fp64_align_unpack_if.slave   io
);
   localparam int W  = 1 + EXP_W + MANT_W;
   localparam int MW = MANT_W + 1;   // hidden bit + fraction
   localparam int AW = MANT_W + 2;   // leading zero + hidden bit + fraction
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [EXP_W-1:0] BIAS_E  = EXP_W'(BIAS);

   // ---------------- handshake ----------------
   logic s1_valid, s2_valid;
   logic s1_load, s2_load;

   assign s2_load     = !s2_valid || io.out_ready;
   assign s1_load     = !s1_valid || s2_load;
   assign io.in_ready = s1_load;

   // ---------------- stage 1: unpack / compare ----------------
   logic              sa, sb;
   logic [EXP_W-1:0]  ea, eb;
   logic [MANT_W-1:0] fa, fb;
   logic [MW-1:0]     ma, mb;
   logic              swap;

   assign sa = io.a[W-1];
   assign sb = io.b[W-1];
   assign ea = io.a[W-2 -: EXP_W];
   assign eb = io.b[W-2 -: EXP_W];
   assign fa = io.a[MANT_W-1:0];
   assign fb = io.b[MANT_W-1:0];

   // exp == 0 flushes to zero: no hidden bit and the fraction is dropped.
   assign ma = (ea != '0) ? {1'b1, fa} : '0;
   assign mb = (eb != '0) ? {1'b1, fb} : '0;

   // Compare on the raw {exp, frac}; ties keep A as the big operand.
   assign swap = {eb, fb} > {ea, fa};

   logic [MW-1:0]    s1_big_d, s1_small_d;
   logic [EXP_W-1:0] s1_exp_d, s1_diff_d;
   logic             s1_sign_d;

   always_comb begin
      s1_big_d   = ma;
      s1_small_d = mb;
      s1_exp_d   = ea;
      s1_diff_d  = ea - eb;
      s1_sign_d  = sa;
      if (swap) begin
         s1_big_d   = mb;
         s1_small_d = ma;
         s1_exp_d   = eb;
         s1_diff_d  = eb - ea;
         s1_sign_d  = sb;
      end
   end

   logic [MW-1:0]    s1_big, s1_small;
   logic [EXP_W-1:0] s1_exp, s1_diff;
   logic             s1_sign, s1_effsub, s1_special;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_big     <= '0;
         s1_small   <= '0;
         s1_exp     <= '0;
         s1_diff    <= '0;
         s1_sign    <= 1'b0;
         s1_effsub  <= 1'b0;
         s1_special <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= io.in_valid;
         if (io.in_valid) begin
            s1_big     <= s1_big_d;
            s1_small   <= s1_small_d;
            s1_exp     <= s1_exp_d;
            s1_diff    <= s1_diff_d;
            s1_sign    <= s1_sign_d;
            s1_effsub  <= sa ^ sb;
            s1_special <= (ea == EXP_MAX) || (eb == EXP_MAX);
         end
      end
   end

   // ---------------- stage 2: align ----------------
   // Bits shifted out are dropped; no guard/sticky is kept.
   logic [AW-1:0] small_al;

   always_comb begin
      small_al = '0;
      if (s1_diff < EXP_W'(AW))
         small_al = {1'b0, s1_small} >> s1_diff;
   end

   logic [EXP_W-1:0] s2_bigshift, s2_smallshift;
   logic [AW-1:0]    s2_bigmant, s2_smallmant;
   logic             s2_sign, s2_effsub, s2_special;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid      <= 1'b0;
         s2_bigshift   <= '0;
         s2_smallshift <= '0;
         s2_bigmant    <= '0;
         s2_smallmant  <= '0;
         s2_sign       <= 1'b0;
         s2_effsub     <= 1'b0;
         s2_special    <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_bigshift   <= s1_exp - BIAS_E;   // wraps: zero operands give -BIAS
            s2_smallshift <= s1_diff;
            s2_bigmant    <= {1'b0, s1_big};
            s2_smallmant  <= small_al;
            s2_sign       <= s1_sign;
            s2_effsub     <= s1_effsub;
            s2_special    <= s1_special;
         end
      end
   end

   assign io.out_valid  = s2_valid;
   assign io.bigshift   = s2_bigshift;
   assign io.smallshift = s2_smallshift;
   assign io.bigmant    = s2_bigmant;
   assign io.smallmant  = s2_smallmant;
   assign io.resultsign = s2_sign;
   assign io.effsub     = s2_effsub;
   assign io.special    = s2_special;
endmodule
